// File: rtl/serdes_var.sv
// Word serialiser/deserialiser with an N-word buffer and a per-command word count (1..N).
// Optional macro SERDES_VAR_ZEROIZE_EN clears each slot as it is serialised in ser-only mode.
module serdes_var #(
  parameter int unsigned W = 64,
  parameter int unsigned N = 4,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cmd_startDes,
  input  logic           cmd_startSer,
  input  logic [CW-1:0]  cmd_numWords,
  output logic           cmd_canReceive,
  input  logic           par_load,
  input  logic [W*N-1:0] par_in,
  output logic [W*N-1:0] par_out,
  input  logic [W-1:0]   des,
  input  logic           des_isReady,
  output logic           des_canReceive,
  output logic           des_isLast,
  output logic [W-1:0]   ser,
  output logic           ser_isReady,
  input  logic           ser_canReceive,
  output logic           ser_isLast
);

  logic [W-1:0]  mem_q [N];
  logic [W-1:0]  mem_d [N];
  logic [CW-1:0] idx_q, idx_d, rem_q, rem_d;
  logic          is_ser_q, is_ser_d, is_des_q, is_des_d;

  logic          start, active, xfer, is_ser, is_des, last;
  logic [CW-1:0] idx_cur, rem_cur;

  assign cmd_canReceive = (rem_q == '0);

  // A start takes effect combinationally so the first word can move on the accept cycle.
  always_comb begin
    start   = cmd_canReceive & (cmd_startSer | cmd_startDes) &
              (cmd_numWords != '0) & (cmd_numWords <= CW'(N));
    is_ser  = start ? cmd_startSer : is_ser_q;
    is_des  = start ? cmd_startDes : is_des_q;
    idx_cur = start ? '0 : idx_q;
    rem_cur = start ? cmd_numWords : rem_q;
    active  = start | (rem_q != '0);
    xfer    = active & (is_des ? des_isReady : ser_canReceive);
    last    = active & (rem_cur == CW'(1));
  end

  assign des_canReceive = active & is_des & (is_ser ? ser_canReceive : 1'b1);
  assign ser_isReady    = active & is_ser & (is_des ? des_isReady : ser_canReceive);
  assign des_isLast     = last;
  assign ser_isLast     = last;

  always_comb begin
    ser = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_cur == CW'(i)) ser = mem_q[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) par_out[W*i +: W] = mem_q[i];
  end

  always_comb begin
    mem_d    = mem_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    is_ser_d = is_ser_q;
    is_des_d = is_des_q;
    if (start) begin
      is_ser_d = cmd_startSer;
      is_des_d = cmd_startDes;
      idx_d    = '0;
      rem_d    = cmd_numWords;
    end
    if (xfer) begin
      for (int i = 0; i < N; i++) begin
        if (idx_cur == CW'(i)) begin
          if (is_des) begin
            mem_d[i] = des;
          end
`ifdef SERDES_VAR_ZEROIZE_EN
          else begin
            mem_d[i] = '0;
          end
`endif
        end
      end
      idx_d = idx_cur + CW'(1);
      rem_d = rem_cur - CW'(1);
      if (rem_cur == CW'(1)) begin
        is_ser_d = 1'b0;
        is_des_d = 1'b0;
      end
    end
    // A start in the same cycle wins over a parallel load.
    if (par_load && cmd_canReceive && !start) begin
      for (int i = 0; i < N; i++) mem_d[i] = par_in[W*i +: W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
      idx_q    <= '0;
      rem_q    <= '0;
      is_ser_q <= 1'b0;
      is_des_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      is_ser_q <= is_ser_d;
      is_des_q <= is_des_d;
    end
  end

endmodule

// File: tb/tb_serdes_var.sv
// Randomised bench for serdes_var against a word-array model of the buffer and commands.
module tb_serdes_var;
  localparam int unsigned W  = 64;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = $clog2(N + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_startDes, cmd_startSer, cmd_canReceive;
  logic [CW-1:0]  cmd_numWords;
  logic           par_load;
  logic [W*N-1:0] par_in, par_out;
  logic [W-1:0]   des, ser;
  logic           des_isReady, des_canReceive, des_isLast;
  logic           ser_isReady, ser_canReceive, ser_isLast;

  serdes_var #(.W(W), .N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_startDes  (cmd_startDes),
    .cmd_startSer  (cmd_startSer),
    .cmd_numWords  (cmd_numWords),
    .cmd_canReceive(cmd_canReceive),
    .par_load      (par_load),
    .par_in        (par_in),
    .par_out       (par_out),
    .des           (des),
    .des_isReady   (des_isReady),
    .des_canReceive(des_canReceive),
    .des_isLast    (des_isLast),
    .ser           (ser),
    .ser_isReady   (ser_isReady),
    .ser_canReceive(ser_canReceive),
    .ser_isLast    (ser_isLast)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mbuf [N];
  logic [W-1:0] src  [N];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [W*N-1:0] got,
                          input logic [W*N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W*N-1:0] model_flat();
    logic [W*N-1:0] r;
    for (int i = 0; i < N; i++) r[W*i +: W] = mbuf[i];
    return r;
  endfunction

  function automatic logic [W*N-1:0] rand_wide();
    logic [W*N-1:0] r;
    for (int i = 0; i < W*N/32; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic idle_inputs();
    cmd_startDes   = 1'b0;
    cmd_startSer   = 1'b0;
    cmd_numWords   = '0;
    par_load       = 1'b0;
    des_isReady    = 1'b0;
    ser_canReceive = 1'b0;
    des            = '0;
  endtask

  // Called just after a rising edge, returns just after a rising edge.
  task automatic do_load(input logic [W*N-1:0] v);
    par_in   = v;
    par_load = 1'b1;
    @(posedge clk); #1;
    par_load = 1'b0;
    for (int i = 0; i < N; i++) mbuf[i] = v[W*i +: W];
    check_eq("par_load", par_out, model_flat());
  endtask

  task automatic do_cmd(input bit d, input bit s, input int n, input int stall_pct,
                        input bit use_pat, input logic [31:0] pat, input bit with_load,
                        input int abort_after);
    logic [W-1:0] old [N];
    int  k   = 0;
    int  cyc = 0;
    bit  xf, sc, dr;
    old = mbuf;
    for (int i = 0; i < N; i++) src[i] = {$urandom, $urandom};
    cmd_startDes = d;
    cmd_startSer = s;
    cmd_numWords = CW'(n);
    if (with_load) begin
      par_in   = rand_wide();
      par_load = 1'b1;
    end
    while (k < n && cyc < 200) begin
      if (k == abort_after) begin
        #2 rst = 1'b1;
        #1;
        check_eq("rst_par_out", par_out, '0);
        check_eq("rst_cmd_canReceive", cmd_canReceive, 1'b1);
        check_eq("rst_des_canReceive", des_canReceive, 1'b0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) mbuf[i] = '0;
        idle_inputs();
        return;
      end
      sc = use_pat ? pat[cyc] : ($urandom_range(99) >= stall_pct);
      dr = ($urandom_range(99) >= stall_pct);
      if (d && s) dr = dr & sc;
      ser_canReceive = sc;
      des_isReady    = d ? dr : 1'b0;
      des            = src[k];
      xf             = d ? dr : sc;
      #4;
      if (cyc > 0) check_eq("cmd_busy", cmd_canReceive, 1'b0);
      check_eq("des_canReceive", des_canReceive, d ? (s ? sc : 1'b1) : 1'b0);
      check_eq("ser_isReady", ser_isReady, s ? xf : 1'b0);
      check_eq("des_isLast", des_isLast, k == n - 1);
      check_eq("ser_isLast", ser_isLast, k == n - 1);
      if (s && xf) check_eq("ser_word", ser, old[k]);
      @(posedge clk); #1;
      cmd_startDes = 1'b0;
      cmd_startSer = 1'b0;
      par_load     = 1'b0;
      if (xf) k++;
      cyc++;
    end
    if (k < n) check_eq("cmd_timeout", k, n);
    idle_inputs();
    for (int i = 0; i < n; i++) begin
      if (d) mbuf[i] = src[i];
`ifdef SERDES_VAR_ZEROIZE_EN
      else if (s) mbuf[i] = '0;
`endif
    end
    check_eq("cmd_done", cmd_canReceive, 1'b1);
    check_eq("par_out", par_out, model_flat());
  endtask

  task automatic ignored_start(input int nw);
    cmd_startDes = 1'b1;
    cmd_numWords = CW'(nw);
    #4;
    check_eq("bad_start_canReceive", cmd_canReceive, 1'b1);
    check_eq("bad_start_des_canReceive", des_canReceive, 1'b0);
    @(posedge clk); #1;
    idle_inputs();
    check_eq("bad_start_idle", cmd_canReceive, 1'b1);
    check_eq("bad_start_par_out", par_out, model_flat());
  endtask

  initial begin
    int  mode, nw;
    logic [W*N-1:0] seq_words;
    rst = 1'b1;
    par_in = '0;
    idle_inputs();
    for (int i = 0; i < N; i++) mbuf[i] = '0;
    #12 rst = 1'b0;
    check_eq("reset_par_out", par_out, '0);
    check_eq("reset_cmd_canReceive", cmd_canReceive, 1'b1);
    check_eq("reset_des_canReceive", des_canReceive, 1'b0);
    check_eq("reset_ser_isReady", ser_isReady, 1'b0);
    check_eq("reset_isLast", {des_isLast, ser_isLast}, 2'b00);
    @(posedge clk); #1;

    // Abort a 4-word deserialise after two words, then a clean 4-word command.
    do_load(rand_wide());
    do_cmd(1'b1, 1'b0, 4, 0, 1'b0, 32'h0, 1'b0, 2);
    do_cmd(1'b1, 1'b0, 4, 0, 1'b0, 32'h0, 1'b0, -1);

    do_cmd(1'b1, 1'b0, 3, 0, 1'b0, 32'h0, 1'b0, -1);

    seq_words = {64'd4, 64'd3, 64'd2, 64'd1};
    do_load(seq_words);
    do_cmd(1'b0, 1'b1, 4, 0, 1'b1, 32'b101101, 1'b0, -1);

    do_load(rand_wide());
    do_cmd(1'b1, 1'b1, 2, 0, 1'b0, 32'h0, 1'b0, -1);

    ignored_start(0);
    ignored_start(5);
    ignored_start(7);
    do_cmd(1'b1, 1'b0, 2, 0, 1'b0, 32'h0, 1'b1, -1);

    do_load(rand_wide());
    do_cmd(1'b0, 1'b1, 2, 0, 1'b0, 32'h0, 1'b0, -1);

    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(3, 1);
      nw   = $urandom_range(N, 1);
      if ($urandom_range(1) == 1) do_load(rand_wide());
      do_cmd(mode[0], mode[1], nw, 30, 1'b0, 32'h0, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
